// File: rtl/timer_pkg.sv
// Shared timer constants: counter width, default prescale, and the
// tick durations used by the traffic controller.
package timer_pkg;

  localparam int TIMER_W = 4;
  localparam int CLKS_PER_TICK_DEFAULT = 100_000_000;

  localparam int T_PED    = 15;
  localparam int T_GREEN  = 10;
  localparam int T_YELLOW = 5;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLKS_PER_TICK enabled
// cycles; clear restarts the phase at 0, a low enable holds it.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_TICK - 1);

  logic [PW-1:0] pre;
  logic          at_last;

  assign at_last = (pre == LAST);
  assign tick    = enable & at_last;

  // Phase counter: clear wins, wraps at LAST, holds while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (enable) begin
      pre <= at_last ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable tick countdown with a floor at zero.
// Optional TIMER_EXPIRED_EN adds a one-cycle timer_expired pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timer_load,
  input  logic               timer_en,
  input  logic [TIMER_W-1:0] timer_init,
  output logic [TIMER_W-1:0] timer_out,
  output logic               timer_busy
`ifdef TIMER_EXPIRED_EN
  ,
  output logic               timer_expired
`endif
);

  logic [TIMER_W-1:0] count;
  logic               tick;
  logic               run;
  logic               nonzero;

  // Load owns the cycle: it freezes the prescaler and restarts its phase.
  assign run = timer_en & ~timer_load;
  assign nonzero = |count;

  tick_prescaler #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_pre (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_load),
    .enable(run),
    .tick  (tick)
  );

  // Count register: load, else decrement on tick down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (timer_load) begin
      count <= timer_init;
    end else if (tick && nonzero) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign timer_out  = count;
  assign timer_busy = nonzero;

`ifdef TIMER_EXPIRED_EN
  // Pulse only on a tick-driven 1 -> 0 step, never on load or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_expired <= 1'b0;
    end else begin
      timer_expired <= tick & ~timer_load & (count == TIMER_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at CLKS_PER_TICK=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       timer_load;
  logic       timer_en;
  logic [3:0] timer_init;
  logic [3:0] timer_out;
  logic       timer_busy;
`ifdef TIMER_EXPIRED_EN
  logic       timer_expired;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  countdown_timer #(
    .CLKS_PER_TICK(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .timer_load(timer_load),
    .timer_en  (timer_en),
    .timer_init(timer_init),
    .timer_out (timer_out),
    .timer_busy(timer_busy)
`ifdef TIMER_EXPIRED_EN
    ,
    .timer_expired(timer_expired)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_exp(input string tag, input int exp);
`ifdef TIMER_EXPIRED_EN
    check(tag, int'(timer_expired), exp);
`endif
  endtask

  task automatic load(input int v, input logic en);
    timer_load = 1'b1;
    timer_en   = en;
    timer_init = 4'(v);
    step();
    timer_load = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    timer_load = 1'b0;
    timer_en = 1'b0;
    timer_init = 4'd0;

    // Reset state, then release with no load.
    #1;
    check("rst_out", int'(timer_out), 0);
    check("rst_busy", int'(timer_busy), 0);
    chk_exp("rst_exp", 0);
    step(3);
    rst = 1'b1;
    timer_en = 1'b1;
    step(6);
    check("post_rst_out", int'(timer_out), 0);

    // Full countdown from 5.
    timer_en = 1'b0;
    load(5, 1'b0);
    check("load5_out", int'(timer_out), 5);
    check("load5_busy", int'(timer_busy), 1);
    timer_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("cd_out_%0d", k), int'(timer_out), 5 - k / 4);
      chk_exp($sformatf("cd_exp_%0d", k), (k == 20) ? 1 : 0);
    end
    check("cd_busy_end", int'(timer_busy), 0);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("floor_out_%0d", k), int'(timer_out), 0);
      chk_exp($sformatf("floor_exp_%0d", k), 0);
    end

    // Pause at count=3, prescaler=2.
    load(5, 1'b0);
    timer_en = 1'b1;
    step(10);
    check("pause_pre", int'(timer_out), 3);
    timer_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("pause_hold_%0d", k), int'(timer_out), 3);
    end
    timer_en = 1'b1;
    step();
    check("resume_1", int'(timer_out), 3);
    step();
    check("resume_2", int'(timer_out), 2);

    // Priority: load with a tick due (prescaler=3).
    step(3);
    check("prio_pre", int'(timer_out), 2);
    load(10, 1'b1);
    check("prio_out", int'(timer_out), 10);
    step(3);
    check("prio_phase3", int'(timer_out), 10);
    step();
    check("prio_phase4", int'(timer_out), 9);

    // Load 0, floor, reload from zero, load 0 again.
    load(0, 1'b0);
    check("ld0_out", int'(timer_out), 0);
    check("ld0_busy", int'(timer_busy), 0);
    chk_exp("ld0_exp", 0);
    timer_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("z_floor_%0d", k), int'(timer_out), 0);
      chk_exp($sformatf("z_exp_%0d", k), 0);
    end
    load(15, 1'b1);
    check("ld15_out", int'(timer_out), 15);
    load(0, 1'b1);
    check("ld0b_out", int'(timer_out), 0);
    check("ld0b_busy", int'(timer_busy), 0);
    chk_exp("ld0b_exp", 0);
    step();
    chk_exp("ld0b_exp2", 0);

    // Async reset mid-count at 7, between edges.
    load(7, 1'b1);
    step(2);
    check("ar_pre", int'(timer_out), 7);
    #2;
    rst = 1'b0;
    #1;
    check("ar_out", int'(timer_out), 0);
    check("ar_busy", int'(timer_busy), 0);
    chk_exp("ar_exp", 0);
    step(3);
    rst = 1'b1;
    step(8);
    check("ar_after", int'(timer_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The module SHALL have one parameter: CLKS_PER_TICK, default 100_000_000, the number of clk cycles per timer decrement (1 s at 100 MHz).
REQ-002 The ports SHALL be, in order:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- timer_load  input  1  load timer_init into the counter.
- timer_en  input  1  count-down enable.
- timer_init  input  4  load value, in ticks.
- timer_out  output  4  current count, registered.
- timer_busy  output  1  high when timer_out != 0.

Function
REQ-003 The block SHALL contain two registers:
- prescaler: width clog2(CLKS_PER_TICK), range 0..CLKS_PER_TICK-1.
- count: 4 bits, drives timer_out directly, no combinational path to outputs.
REQ-004 Load: when timer_load=1 at a rising edge, count SHALL become timer_init and prescaler SHALL become 0. timer_out shows the new value one cycle after the load edge.
REQ-005 Simultaneous load and enable: timer_load SHALL take priority over timer_en. The load cycle SHALL neither decrement count nor advance prescaler.
REQ-006 Counting: when timer_load=0 and timer_en=1, prescaler SHALL increment each cycle.
REQ-007 Tick: when prescaler=CLKS_PER_TICK-1, prescaler SHALL wrap to 0 on the next edge, and count SHALL decrement by 1 on that same edge if count != 0.
REQ-008 Hold: when timer_load=0 and timer_en=0, prescaler and count SHALL both hold. The tick phase is preserved across pauses.
REQ-009 Floor: count SHALL saturate at 0 and never wrap to 15. With timer_en=1 at count=0, prescaler keeps cycling and count stays 0.
REQ-010 Latency: a load of N followed by continuous enable SHALL reach timer_out=0 exactly N*CLKS_PER_TICK cycles after the first enabled cycle.
REQ-011 Load value 0: a load with timer_init=0 SHALL give timer_out=0 and timer_busy=0 on the next cycle.
REQ-012 Reload: a load SHALL take effect from any count value, including mid-tick. Prescaler restarts at 0.
REQ-013 timer_busy SHALL be registered-equivalent, i.e. decoded only from the count register.

Reset
REQ-014 While rst=0, count, prescaler and the expired register (REQ-017) SHALL be 0 asynchronously. Outputs: timer_out=0, timer_busy=0, timer_expired=0.
REQ-015 Reset asserted mid-count SHALL clear all state immediately, independent of clk.
REQ-016 After rst deasserts, the first state change SHALL occur at the first rising clk edge. Until a load occurs, count stays 0.

Configuration
REQ-017 Macro TIMER_EXPIRED_EN. When defined:
- adds output timer_expired (1 bit, registered);
- timer_expired pulses high for exactly one cycle when count changes from 1 to 0 through a tick;
- no pulse for a load of 0 or for reset.
When undefined, the port and its register SHALL be absent. All other behaviour is identical.

Structure
REQ-018 Shared package timer_pkg SHALL hold:
- TIMER_W = 4;
- CLKS_PER_TICK_DEFAULT = 100_000_000;
- named tick constants used by the traffic controller: T_PED = 15, T_GREEN = 10, T_YELLOW = 5.
REQ-019 Sub-module tick_prescaler SHALL hold the prescaler:
- inputs: clk, rst, clear, enable;
- output: tick, a one-cycle pulse high when prescaler = CLKS_PER_TICK-1 and enable=1.
The count logic SHALL stay in countdown_timer.

Verification (CLKS_PER_TICK=4)
REQ-020 Reset: rst=0 for 3 cycles at any prior state -> timer_out=0 and timer_busy=0 immediately; after release, timer_out remains 0.
REQ-021 Full countdown: load 5 for one cycle, then timer_en=1 continuously.
- timer_out=5 one cycle after the load edge;
- values 4,3,2,1,0 at 4-cycle intervals;
- 0 reached 20 cycles after the first enabled cycle; timer_busy falls with it;
- timer_out stays 0 for 10 further cycles;
- with TIMER_EXPIRED_EN, exactly one timer_expired pulse, on the cycle count becomes 0.
REQ-022 Pause: at count=3 with prescaler=2, drop timer_en for 10 cycles -> timer_out holds 3. Re-enable -> count becomes 2 exactly 2 enabled cycles later.
REQ-023 Priority: timer_load=1, timer_en=1, timer_init=10 with a tick due that cycle -> timer_out=10, no decrement, prescaler=0.
REQ-024 Reload and floor: at count=0 with timer_en=1, load 15 -> timer_out=15. Separately, load 0 -> timer_out=0, timer_busy=0, no expired pulse.
REQ-025 Async reset: assert rst mid-count at count=7, between clk edges -> timer_out=0 before the next clk edge.
